// File: rtl/if_pc_fetch.sv
// Instruction-fetch stage: PC register, single-outstanding instruction-memory read
// handshake, redirect (branch/jump) target generation and cancellation of stale fetches.
module if_pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        br_taken,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        id_ready
);

    typedef enum logic [1:0] {
        START = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] redir_r, redir_s;
    logic        cancel_r, cancel_s;
    logic        if_valid_r, if_valid_s;
    logic [31:0] if_pc_r, if_pc_s;
    logic [31:0] if_inst_r, if_inst_s;
    logic        inst_req_r;
    logic        redirect_s;
    logic [31:0] pc4_s;
    logic [31:0] target_s;

    // Redirect target; a jump overrides a simultaneous branch so the stage never stalls
    always_comb begin
        pc4_s      = br_pc + 32'd4;
        redirect_s = br_taken | jump;
        if (jump) begin
            target_s = {pc4_s[31:28], jump_index, 2'b00};
        end else begin
            target_s = pc4_s + br_offset;
        end
    end

    // Next-state and datapath update for the fetch sequencer
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        redir_s    = redir_r;
        cancel_s   = cancel_r;
        if_valid_s = if_valid_r;
        if_pc_s    = if_pc_r;
        if_inst_s  = if_inst_r;
        case (state_r)
            START: begin
                if (redirect_s) begin
                    pc_s = target_s;
                end else begin
                    pc_s = pc_r;
                end
                state_s = REQ;
            end
            REQ: begin
                // The address already on the bus must stay put; the read is cancelled later.
                if (redirect_s) begin
                    cancel_s = 1'b1;
                    redir_s  = target_s;
                end else begin
                    cancel_s = cancel_r;
                end
                if (inst_addr_ok) begin
                    state_s = WAIT;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                if (inst_data_ok) begin
                    if (redirect_s) begin
                        pc_s     = target_s;
                        redir_s  = target_s;
                        cancel_s = 1'b0;
                        state_s  = REQ;
                    end else if (cancel_r) begin
                        pc_s     = redir_r;
                        cancel_s = 1'b0;
                        state_s  = REQ;
                    end else begin
                        if_inst_s  = inst_rdata;
                        if_pc_s    = pc_r;
                        if_valid_s = 1'b1;
                        pc_s       = pc_r + 32'd4;
                        state_s    = HOLD;
                    end
                end else if (redirect_s) begin
                    cancel_s = 1'b1;
                    redir_s  = target_s;
                end else begin
                    state_s = WAIT;
                end
            end
            HOLD: begin
                if (redirect_s) begin
                    if_valid_s = 1'b0;
                    pc_s       = target_s;
                    state_s    = REQ;
                end else if (id_ready) begin
                    if_valid_s = 1'b0;
                    state_s    = REQ;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = START;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= START;
            pc_r       <= RESET_PC;
            redir_r    <= 32'd0;
            cancel_r   <= 1'b0;
            if_valid_r <= 1'b0;
            if_pc_r    <= 32'd0;
            if_inst_r  <= 32'd0;
            inst_req_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            redir_r    <= redir_s;
            cancel_r   <= cancel_s;
            if_valid_r <= if_valid_s;
            if_pc_r    <= if_pc_s;
            if_inst_r  <= if_inst_s;
            inst_req_r <= (state_s == REQ);
        end
    end

    assign inst_req  = inst_req_r;
    assign inst_addr = pc_r;
    assign if_valid  = if_valid_r;
    assign if_pc     = if_pc_r;
    assign if_inst   = if_inst_r;

endmodule

// File: tb/tb_if_pc_fetch.sv
// Bench for if_pc_fetch: behavioural instruction memory with programmable handshake
// latencies, a table of redirect targets, and directed multi-cycle corner cases.
module tb_if_pc_fetch;

    logic        clk = 1'b0;
    logic        resetn;
    logic        br_taken, jump, id_ready;
    logic [31:0] br_pc, br_offset;
    logic [25:0] jump_index;
    logic        inst_req, inst_addr_ok, inst_data_ok, if_valid;
    logic [31:0] inst_addr, inst_rdata, if_pc, if_inst;

    if_pc_fetch dut (
        .clk(clk), .resetn(resetn), .br_taken(br_taken), .br_pc(br_pc),
        .br_offset(br_offset), .jump(jump), .jump_index(jump_index),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .if_valid(if_valid),
        .if_pc(if_pc), .if_inst(if_inst), .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        br;
        logic        jmp;
        logic [31:0] pc;
        logic [31:0] off;
        logic [25:0] idx;
        logic [31:0] exp;
    } vec_t;

    int total = 0;
    int bad = 0;
    int addr_lat = 0, data_lat = 0;
    int acnt = 0, dcnt = 0, cyc = 0, vcnt = 0, dok_cnt = 0;
    int first_req = -1, first_valid = -1;
    bit pend = 1'b0;
    logic [31:0] paddr;
    logic [31:0] acc_q[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_inst[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int n);
        for (int k = 0; k < 200 && acc_q.size() < n; k++) step();
        chk("acc_timeout", 32'(acc_q.size() >= n), 32'd1);
    endtask

    task automatic wait_valid();
        for (int k = 0; k < 200 && if_valid !== 1'b1; k++) step();
        chk("valid_timeout", 32'(if_valid), 32'd1);
    endtask

    task automatic pulse_ready();
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
    endtask

    // Memory responder and observer, acting on the falling edge
    initial begin
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'd0;
        forever begin
            @(negedge clk);
            cyc++;
            inst_addr_ok = 1'b0;
            inst_data_ok = 1'b0;
            if (pend) begin
                if (dcnt == 0) begin
                    inst_data_ok = 1'b1;
                    inst_rdata   = mem_word(paddr);
                    pend         = 1'b0;
                    dok_cnt++;
                end else begin
                    dcnt--;
                end
            end else if (inst_req === 1'b1) begin
                if (first_req < 0) first_req = cyc;
                if (acnt >= addr_lat) begin
                    inst_addr_ok = 1'b1;
                    paddr = inst_addr;
                    acc_q.push_back(inst_addr);
                    pend = 1'b1;
                    dcnt = data_lat;
                    acnt = 0;
                end else begin
                    acnt++;
                end
            end
            if (resetn && if_valid === 1'b1) begin
                vcnt++;
                if (first_valid < 0) first_valid = cyc;
                if (id_ready && !br_taken && !jump) begin
                    got_pc.push_back(if_pc);
                    got_inst.push_back(if_inst);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int n, v0, d0;
        vecs[0] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0000_0010, 26'h000_0000, 32'h0000_1014};
        vecs[1] = '{1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0000_0008, 26'h000_0000, 32'h0000_0004};
        vecs[2] = '{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFC, 26'h000_0000, 32'h8000_0000};
        vecs[3] = '{1'b0, 1'b1, 32'h1234_5678, 32'h0000_0000, 26'h3FF_FFFF, 32'h1FFF_FFFC};
        vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 26'h000_0001, 32'h0000_0004};
        vecs[5] = '{1'b1, 1'b1, 32'hBFC0_0000, 32'h0000_0100, 26'h000_0010, 32'hB000_0040};
        vecs[6] = '{1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0000_0008, 26'h000_0000, 32'hFFFF_FFFC};

        resetn = 1'b0; br_taken = 1'b0; jump = 1'b0; id_ready = 1'b1;
        br_pc = 32'd0; br_offset = 32'd0; jump_index = 26'd0;
        step(); step();
        chk("rst_inst_req", 32'(inst_req), 32'd0);
        chk("rst_inst_addr", inst_addr, 32'hBFC0_0000);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        resetn = 1'b1;

        // Sequential fetch with single-cycle memory
        for (int k = 0; k < 200 && got_pc.size() < 3; k++) step();
        chk("seq_count", 32'(got_pc.size()), 32'd3);
        chk("seq_valid_cycles", 32'(vcnt), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("seq_addr", acc_q[i], 32'hBFC0_0000 + 32'(4 * i));
            chk("seq_if_pc", got_pc[i], 32'hBFC0_0000 + 32'(4 * i));
            chk("seq_if_inst", got_inst[i], mem_word(32'hBFC0_0000 + 32'(4 * i)));
        end
        // inst_req cycle, wait cycle, then if_valid: three cycles spanned
        chk("min_latency", 32'(first_valid - first_req), 32'd2);

        // Backpressure in HOLD
        id_ready = 1'b0;
        wait_valid();
        chk("bp_if_pc", if_pc, 32'hBFC0_000C);
        chk("bp_if_inst", if_inst, mem_word(32'hBFC0_000C));
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 32'(if_valid), 32'd1);
            chk("bp_pc_stable", if_pc, 32'hBFC0_000C);
            chk("bp_no_req", 32'(inst_req), 32'd0);
        end

        // Branch while holding, with id_ready also high: held instruction dropped
        n = acc_q.size();
        br_taken = 1'b1; br_pc = 32'hBFC0_0010; br_offset = 32'hFFFF_FFF0; id_ready = 1'b1;
        step();
        br_taken = 1'b0; id_ready = 1'b0;
        chk("hold_br_valid_drop", 32'(if_valid), 32'd0);
        wait_acc(n + 1);
        chk("hold_br_addr", acc_q[n], 32'hBFC0_0004);
        wait_valid();
        chk("hold_br_if_pc", if_pc, 32'hBFC0_0004);

        // Target arithmetic table, each redirect applied in HOLD
        for (int i = 0; i < 7; i++) begin
            n = acc_q.size();
            br_taken = vecs[i].br; jump = vecs[i].jmp;
            br_pc = vecs[i].pc; br_offset = vecs[i].off; jump_index = vecs[i].idx;
            step();
            br_taken = 1'b0; jump = 1'b0;
            wait_acc(n + 1);
            chk($sformatf("tbl%0d_addr", i), acc_q[n], vecs[i].exp);
            wait_valid();
            chk($sformatf("tbl%0d_if_pc", i), if_pc, vecs[i].exp);
        end

        // PC increment wraps to zero
        n = acc_q.size();
        pulse_ready();
        wait_acc(n + 1);
        chk("wrap_addr", acc_q[n], 32'd0);
        wait_valid();

        // Jump during WAIT with data delayed four cycles
        data_lat = 4;
        n = acc_q.size();
        pulse_ready();
        wait_acc(n + 1);
        chk("wait_first_addr", acc_q[n], 32'h0000_0004);
        v0 = vcnt; d0 = dok_cnt;
        jump = 1'b1; br_pc = 32'hBFC0_0020; jump_index = 26'h000_0100;
        step();
        jump = 1'b0; data_lat = 0;
        wait_acc(n + 2);
        chk("wait_redir_addr", acc_q[n + 1], 32'hB000_0400);
        chk("wait_no_valid", 32'(vcnt), 32'(v0));
        chk("wait_data_seen", 32'(dok_cnt), 32'(d0 + 1));
        wait_valid();
        chk("wait_if_pc", if_pc, 32'hB000_0400);
        chk("wait_if_inst", if_inst, mem_word(32'hB000_0400));

        // Branch in REQ while addr_ok is held low three cycles
        addr_lat = 3;
        n = acc_q.size();
        pulse_ready();
        chk("req_entered", 32'(inst_req), 32'd1);
        v0 = vcnt;
        br_taken = 1'b1; br_pc = 32'h0000_0100; br_offset = 32'h0000_0020;
        step();
        br_taken = 1'b0;
        for (int k = 0; k < 20 && acc_q.size() == n; k++) begin
            chk("req_addr_stable", inst_addr, 32'hB000_0404);
            step();
        end
        addr_lat = 0;
        wait_acc(n + 1);
        chk("req_old_addr", acc_q[n], 32'hB000_0404);
        wait_acc(n + 2);
        chk("req_redir_addr", acc_q[n + 1], 32'h0000_0124);
        chk("req_no_valid", 32'(vcnt), 32'(v0));
        wait_valid();
        chk("req_if_pc", if_pc, 32'h0000_0124);

        // Asynchronous reset while waiting for data; data arrives during reset
        data_lat = 4;
        n = acc_q.size();
        pulse_ready();
        wait_acc(n + 1);
        d0 = dok_cnt;
        resetn = 1'b0;
        #1;
        chk("arst_inst_req", 32'(inst_req), 32'd0);
        chk("arst_inst_addr", inst_addr, 32'hBFC0_0000);
        chk("arst_if_valid", 32'(if_valid), 32'd0);
        chk("arst_if_pc", if_pc, 32'd0);
        chk("arst_if_inst", if_inst, 32'd0);
        for (int i = 0; i < 8; i++) step();
        chk("arst_late_data", 32'(dok_cnt), 32'(d0 + 1));
        chk("arst_valid_held", 32'(if_valid), 32'd0);
        data_lat = 0; id_ready = 1'b1;
        n = acc_q.size();
        resetn = 1'b1;
        wait_acc(n + 1);
        chk("arst_first_addr", acc_q[n], 32'hBFC0_0000);
        wait_valid();
        chk("arst_if_pc_after", if_pc, 32'hBFC0_0000);
        chk("arst_if_inst_after", if_inst, mem_word(32'hBFC0_0000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_pc_fetch.md
Name: if_pc_fetch

Overview:
- Instruction-fetch stage: holds the PC, issues instruction-memory reads over a req/addr_ok/data_ok handshake, and presents one fetched instruction at a time to decode.
- Computes branch targets from the word-aligned offset produced by the immediate shift-left-by-2 stage: target = br_pc + 4 + br_offset.
- Handles jump targets and redirects that arrive while a fetch is in flight.
- No branch delay slot: any younger fetch is discarded on redirect.

Parameters:
RESET_PC, 32'hBFC0_0000, PC loaded on reset; first fetch address

Ports:
clk  in  1  clock, rising edge
resetn  in  1  reset, asynchronous assert, active-low
br_taken  in  1  decode: branch resolved taken this cycle (single-cycle pulse)
br_pc  in  32  PC of the redirecting branch/jump instruction
br_offset  in  32  sign-extended immediate shifted left 2 (already word-aligned)
jump  in  1  decode: J-type jump this cycle (single-cycle pulse)
jump_index  in  26  J-type instr_index field
inst_req  out  1  instruction-memory read request
inst_addr  out  32  read address; stable while inst_req=1 and inst_addr_ok=0
inst_addr_ok  in  1  memory accepted address this cycle
inst_data_ok  in  1  read data valid this cycle
inst_rdata  in  32  read data
if_valid  out  1  if_pc/if_inst valid toward decode
if_pc  out  32  PC of presented instruction
if_inst  out  32  presented instruction
id_ready  in  1  decode consumes if_* when if_valid=1

Behaviour:
- Reset (resetn=0, async):
  - Outputs: inst_req=0, inst_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=0.
  - Internal: pc_r=RESET_PC, cancel=0, state=START.
  - Reset mid-transaction abandons everything; a late inst_data_ok after reset is ignored.
- States: START, REQ, WAIT, HOLD.
  - START: one cycle after reset release, then REQ.
  - REQ: inst_req=1, inst_addr=pc_r. On inst_addr_ok -> WAIT; inst_req drops next cycle.
  - WAIT: inst_req=0. On inst_data_ok:
    - cancel=1: drop data, pc_r<=redir_r, cancel<=0, -> REQ.
    - else: if_inst<=inst_rdata, if_pc<=pc_r, if_valid<=1, pc_r<=pc_r+4, -> HOLD.
  - HOLD: if_valid=1. On id_ready: if_valid<=0, -> REQ (next request the following cycle).
- Minimum latency from inst_req to if_valid is 3 cycles with addr_ok and data_ok both same-cycle.
- Redirect = br_taken | jump; target:
  - branch: br_pc + 4 + br_offset, modulo 2^32.
  - jump: {pc4[31:28], jump_index, 2'b00}, pc4 = br_pc + 4.
  - jump and br_taken both high: jump wins (protocol error, must not hang).
- Redirect handling by state:
  - START: pc_r<=target; first fetch goes to target.
  - REQ, no addr_ok this cycle: inst_addr stays pc_r. Set cancel=1, redir_r<=target; the accepted request is later cancelled.
  - REQ with addr_ok in the same cycle: cancel=1, redir_r<=target, -> WAIT.
  - WAIT: cancel=1, redir_r<=target.
    - If data_ok is in the same cycle: this data is dropped, pc_r<=target, -> REQ.
  - HOLD: held instruction is discarded even if id_ready=1 that cycle. if_valid<=0, pc_r<=target, -> REQ.
- Second redirect while cancel=1 overwrites redir_r (newest wins). Only one outstanding read ever exists.
- if_pc/if_inst hold their value while if_valid=0.
- PC increment wraps 32'hFFFF_FFFC -> 0.

Test Plan:
- Reset/sequential fetch: release resetn; memory with 1-cycle addr_ok/data_ok, id_ready=1 -> first inst_addr=BFC00000; if_pc sequence BFC00000, BFC00004, BFC00008; if_valid high one cycle each.
- Backpressure: id_ready=0 for 5 cycles in HOLD -> if_valid, if_pc, if_inst stable; no inst_req until id_ready=1.
- Branch in HOLD: br_pc=BFC00010, br_offset=FFFFFFF0 -> held instruction dropped; next inst_addr=BFC00004.
- Redirect during WAIT, data_ok delayed 4 cycles: jump, br_pc=BFC00020, jump_index=0x0000100 -> returned data dropped; no if_valid; next inst_addr=B0000400.
- Redirect in REQ with addr_ok held low 3 cycles -> inst_addr stays at the old PC until accepted; then cancelled; following request goes to the target.
- Async reset asserted in WAIT, data_ok arrives during reset -> all outputs at reset values; after release the first inst_addr is BFC00000.
